// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter merging NREQ requesters into one FIFO write port.
// Define FIFO_ARB_BURST_EN for multi-beat bursts; otherwise grants rotate every beat.
module fifo_wr_arb #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           gnt,
  input  logic                      fifo_full,
  output logic                      wr_en,
  output logic [WIDTH-1:0]          wr_data,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   owner
);

  localparam int IDXW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("fifo_wr_arb: NREQ must be 2..8");
  end
  if (BURST < 1 || BURST > 16) begin : g_bad_burst
    $error("fifo_wr_arb: BURST must be 1..16");
  end

  // Index arithmetic modulo NREQ, valid for non-power-of-two NREQ.
  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s -= NREQ;
    return IDXW'(s);
  endfunction

  logic [IDXW-1:0] r_rr_ptr;
  logic [IDXW-1:0] r_owner;
  logic [IDXW-1:0] w_rr_ptr_nxt;
  logic [IDXW-1:0] w_owner_nxt;
  logic [IDXW-1:0] w_rr_sel;
  logic [IDXW-1:0] w_sel;

`ifdef FIFO_ARB_BURST_EN
  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  localparam logic [4:0] BURST_LEN = 5'(BURST);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_beat_cnt;
  logic [4:0] w_beat_cnt_nxt;
`endif

  // Scan downward so the last hit written is the closest one above rr_ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    w_rr_sel = r_rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_add(r_rr_ptr, k)]) w_rr_sel = wrap_add(r_rr_ptr, k);
    end
  end

`ifdef FIFO_ARB_BURST_EN
  assign w_sel = (r_state == ST_BURST) ? r_owner : w_rr_sel;
  assign busy  = (r_state == ST_BURST) & ~wr_rst;
`else
  assign w_sel = w_rr_sel;
  assign busy  = 1'b0;
`endif

  always_comb begin
    gnt        = '0;
    gnt[w_sel] = req[w_sel] & ~fifo_full & ~wr_rst;
  end

  assign wr_en   = |gnt;
  assign wr_data = wr_en ? req_data[w_sel*WIDTH +: WIDTH] : '0;
  assign owner   = r_owner;

  always_comb begin
    w_rr_ptr_nxt = r_rr_ptr;
    w_owner_nxt  = r_owner;
`ifdef FIFO_ARB_BURST_EN
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (wr_en) begin
          w_owner_nxt    = w_sel;
          w_beat_cnt_nxt = 5'd1;
          if (BURST > 1) w_state_nxt  = ST_BURST;
          else           w_rr_ptr_nxt = wrap_add(w_sel, 1);
        end
      end
      ST_BURST: begin
        // A full FIFO freezes the burst in place; it resumes when space frees up.
        if (!fifo_full) begin
          if (req[r_owner]) begin
            w_beat_cnt_nxt = r_beat_cnt + 5'd1;
            if (r_beat_cnt + 5'd1 == BURST_LEN) begin
              w_state_nxt  = ST_IDLE;
              w_rr_ptr_nxt = wrap_add(r_owner, 1);
            end
          end else begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = wrap_add(r_owner, 1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
`else
    if (wr_en) begin
      w_owner_nxt  = w_sel;
      w_rr_ptr_nxt = wrap_add(w_sel, 1);
    end
`endif
  end

  always_ff @(posedge wr_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (wr_rst) begin
      r_rr_ptr   <= '0;
      r_owner    <= '0;
`ifdef FIFO_ARB_BURST_EN
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
`endif
    end else begin
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
`ifdef FIFO_ARB_BURST_EN
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed, table-driven bench for fifo_wr_arb (NREQ=4, WIDTH=8, BURST=4).
// Expectations follow FIFO_ARB_BURST_EN when it is defined, per-beat round robin otherwise.
module tb_fifo_wr_arb;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        full;
    logic [3:0]  gnt;
    logic        wr_en;
    logic [7:0]  wdata;
    logic        busy;
    logic [1:0]  owner;
  } vec_t;

  localparam logic [31:0] D0 = 32'h4433_2211;
  localparam logic [31:0] DA = 32'hA533_2211;

  logic        wr_clk;
  logic        wr_rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        busy;
  logic [1:0]  owner;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  fifo_wr_arb #(.WIDTH(8), .NREQ(4), .BURST(4)) dut (
    .wr_clk   (wr_clk),
    .wr_rst   (wr_rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .fifo_full(fifo_full),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .busy     (busy),
    .owner    (owner)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] rq, input logic [31:0] d, input logic full,
                     input logic [3:0] g, input logic we, input logic [7:0] wd,
                     input logic b, input logic [1:0] own);
    vec_t v;
    v = '{rst: rst, req: rq, data: d, full: full, gnt: g, wr_en: we, wdata: wd, busy: b, owner: own};
    vecs.push_back(v);
  endtask

  // Drive at the falling edge, compare 1ns later, then let one rising edge pass.
  task automatic apply(input vec_t v, input string tag);
    wr_rst    = v.rst;
    req       = v.req;
    req_data  = v.data;
    fifo_full = v.full;
    #1;
    check({tag, " gnt"},     32'(gnt),     32'(v.gnt));
    check({tag, " wr_en"},   32'(wr_en),   32'(v.wr_en));
    check({tag, " wr_data"}, 32'(wr_data), 32'(v.wdata));
    check({tag, " busy"},    32'(busy),    32'(v.busy));
    check({tag, " owner"},   32'(owner),   32'(v.owner));
    @(posedge wr_clk);
    @(negedge wr_clk);
  endtask

  initial begin
    //   rst  req      data full gnt      we   wdata  busy own
`ifdef FIFO_ARB_BURST_EN
    add(1, 4'b1111, D0, 0, 4'b0000, 0, 8'h00, 0, 2'd0); // second reset cycle
    add(0, 4'b1111, D0, 0, 4'b0001, 1, 8'h11, 0, 2'd0); // burst to 0, four beats
    add(0, 4'b1111, D0, 0, 4'b0001, 1, 8'h11, 1, 2'd0);
    add(0, 4'b1111, D0, 0, 4'b0001, 1, 8'h11, 1, 2'd0);
    add(0, 4'b1111, D0, 0, 4'b0001, 1, 8'h11, 1, 2'd0);
    add(0, 4'b1111, D0, 0, 4'b0010, 1, 8'h22, 0, 2'd0); // no bubble, owner 1
    add(0, 4'b1111, D0, 0, 4'b0010, 1, 8'h22, 1, 2'd1);
    add(0, 4'b1111, D0, 1, 4'b0000, 0, 8'h00, 1, 2'd1); // FIFO full for 3 cycles
    add(0, 4'b1111, D0, 1, 4'b0000, 0, 8'h00, 1, 2'd1);
    add(0, 4'b1111, D0, 1, 4'b0000, 0, 8'h00, 1, 2'd1);
    add(0, 4'b1111, D0, 0, 4'b0010, 1, 8'h22, 1, 2'd1); // burst resumes: beats 3,4
    add(0, 4'b1111, D0, 0, 4'b0010, 1, 8'h22, 1, 2'd1);
    add(0, 4'b1111, D0, 0, 4'b0100, 1, 8'h33, 0, 2'd1); // rr_ptr reached 2
    add(1, 4'b1100, D0, 0, 4'b0000, 0, 8'h00, 0, 2'd2); // reset in beat 2 of owner 2
    add(0, 4'b1100, D0, 0, 4'b0100, 1, 8'h33, 0, 2'd0); // lowest active after release
    add(0, 4'b1100, D0, 0, 4'b0100, 1, 8'h33, 1, 2'd2); // full 4-beat burst follows
    add(0, 4'b1100, D0, 0, 4'b0100, 1, 8'h33, 1, 2'd2);
    add(0, 4'b1100, D0, 0, 4'b0100, 1, 8'h33, 1, 2'd2);
    add(0, 4'b1100, D0, 0, 4'b1000, 1, 8'h44, 0, 2'd2);
    add(0, 4'b1000, DA, 0, 4'b1000, 1, 8'hA5, 1, 2'd3);
    add(0, 4'b1000, DA, 0, 4'b1000, 1, 8'hA5, 1, 2'd3);
    add(0, 4'b1000, DA, 0, 4'b1000, 1, 8'hA5, 1, 2'd3);
    add(0, 4'b1001, D0, 0, 4'b0001, 1, 8'h11, 0, 2'd3); // rr_ptr wrapped 3 -> 0
    add(0, 4'b1110, D0, 0, 4'b0000, 0, 8'h00, 1, 2'd0); // owner 0 dropped: bubble
    add(0, 4'b1110, D0, 0, 4'b0010, 1, 8'h22, 0, 2'd0);
    add(0, 4'b0000, D0, 0, 4'b0000, 0, 8'h00, 1, 2'd1); // owner 1 dropped: bubble
    add(0, 4'b0000, D0, 0, 4'b0000, 0, 8'h00, 0, 2'd1); // idle, nothing requested
`else
    add(1, 4'b1111, D0, 0, 4'b0000, 0, 8'h00, 0, 2'd0); // second reset cycle
    add(0, 4'b1111, D0, 0, 4'b0001, 1, 8'h11, 0, 2'd0); // per-beat rotation 0,1,2,3,0,1
    add(0, 4'b1111, D0, 0, 4'b0010, 1, 8'h22, 0, 2'd0);
    add(0, 4'b1111, D0, 0, 4'b0100, 1, 8'h33, 0, 2'd1);
    add(0, 4'b1111, D0, 0, 4'b1000, 1, 8'h44, 0, 2'd2);
    add(0, 4'b1111, D0, 0, 4'b0001, 1, 8'h11, 0, 2'd3);
    add(0, 4'b1111, D0, 0, 4'b0010, 1, 8'h22, 0, 2'd0);
    add(0, 4'b0000, D0, 0, 4'b0000, 0, 8'h00, 0, 2'd1); // nothing requested
    add(0, 4'b1111, D0, 1, 4'b0000, 0, 8'h00, 0, 2'd1); // FIFO full
    add(0, 4'b0011, D0, 0, 4'b0001, 1, 8'h11, 0, 2'd1); // search from 2 wraps to 0
    add(0, 4'b1000, D0, 0, 4'b1000, 1, 8'h44, 0, 2'd0);
    add(0, 4'b1000, DA, 0, 4'b1000, 1, 8'hA5, 0, 2'd3);
    add(0, 4'b1001, D0, 0, 4'b0001, 1, 8'h11, 0, 2'd3); // rr_ptr wrapped 3 -> 0
    add(1, 4'b1100, D0, 0, 4'b0000, 0, 8'h00, 0, 2'd0); // reset pulse
    add(0, 4'b1100, D0, 0, 4'b0100, 1, 8'h33, 0, 2'd0); // lowest active after release
    add(0, 4'b1100, D0, 0, 4'b1000, 1, 8'h44, 0, 2'd2);
`endif

    wr_rst    = 1'b1;
    req       = 4'b1111;
    req_data  = D0;
    fifo_full = 1'b0;
    @(posedge wr_clk);
    @(negedge wr_clk);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Multi-cycle stall with every requester waiting, then release.
    begin
      vec_t v;
`ifdef FIFO_ARB_BURST_EN
      v = '{rst: 0, req: 4'b1111, data: D0, full: 1, gnt: 4'b0000, wr_en: 0, wdata: 8'h00, busy: 0, owner: 2'd1};
`else
      v = '{rst: 0, req: 4'b1111, data: D0, full: 1, gnt: 4'b0000, wr_en: 0, wdata: 8'h00, busy: 0, owner: 2'd3};
`endif
      for (int c = 0; c < 3; c++) apply(v, $sformatf("stall%0d", c));
      v.full = 1'b0;
      v.wr_en = 1'b1;
`ifdef FIFO_ARB_BURST_EN
      v.gnt   = 4'b0100;
      v.wdata = 8'h33;
`else
      v.gnt   = 4'b0001;
      v.wdata = 8'h11;
`endif
      apply(v, "release");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of one data beat (matches the FIFO `width).
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter BURST, default 4, maximum consecutive beats per grant (1..16).
REQ-004 SHALL have port wr_clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port wr_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  NREQ  per-requester data-valid.
REQ-007 SHALL have port req_data  input  NREQ*WIDTH  packed beats; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port gnt  output  NREQ  one-hot; gnt[i]=1 means requester i's beat is accepted this cycle.
REQ-009 SHALL have port fifo_full  input  1  full flag from the FIFO write side.
REQ-010 SHALL have port wr_en  output  1  FIFO write enable.
REQ-011 SHALL have port wr_data  output  WIDTH  FIFO write data.
REQ-012 SHALL have port busy  output  1  high while in state BURST.
REQ-013 SHALL have port owner  output  clog2(NREQ)  index of the current or most recent grantee.

Function
REQ-014 SHALL implement states IDLE and BURST; registers: rr_ptr, owner, beat_cnt (5 bits).
REQ-015 IDLE: SHALL select sel = first i with req[i]=1, searching from rr_ptr upward modulo NREQ.
REQ-016 BURST: SHALL set sel = owner, and SHALL consider only req[owner].
REQ-017 SHALL drive gnt[sel] = req[sel] & !fifo_full & !wr_rst combinationally; all other gnt bits 0.
REQ-018 SHALL drive wr_en = |gnt, and wr_data = req_data slice of sel when wr_en=1, else 0; a beat accepted in cycle n is written to the FIFO on that same edge (zero latency).
REQ-019 On an IDLE transfer: owner<=sel, beat_cnt<=1; next state BURST if BURST>1, else stay IDLE with rr_ptr<=sel+1 mod NREQ.
REQ-020 On a BURST transfer: beat_cnt<=beat_cnt+1; when the new count equals BURST, SHALL go to IDLE with rr_ptr<=owner+1 mod NREQ.
REQ-021 In BURST with req[owner]=0: no grant that cycle; SHALL go to IDLE with rr_ptr<=owner+1 mod NREQ (one-cycle bubble).
REQ-022 With fifo_full=1: no grant; state, beat_cnt and rr_ptr SHALL hold; the burst resumes when full deasserts.
REQ-023 With no requests in IDLE: SHALL hold all state, and gnt, wr_en and wr_data SHALL be 0.
REQ-024 Pointer wrap: SHALL advance NREQ-1 to 0.

Reset
REQ-025 While wr_rst=1 at a rising edge: state<=IDLE, rr_ptr<=0, owner<=0, beat_cnt<=0.
REQ-026 While wr_rst=1: gnt=0, wr_en=0, wr_data=0, busy=0, regardless of req.
REQ-027 Reset asserted mid-burst SHALL abandon the burst; the first grant after release goes to the lowest-index active requester.

Configuration
REQ-028 Macro FIFO_ARB_BURST_EN defined: burst behaviour per REQ-016, REQ-019..021.
REQ-029 FIFO_ARB_BURST_EN undefined: no BURST state; busy tied 0; every transfer sets rr_ptr<=sel+1 mod NREQ (per-beat round robin); BURST parameter ignored.

Verification
REQ-030 Reset: wr_rst=1 for 2 cycles with req=4'b1111 -> gnt=0, wr_en=0, busy=0; after release the first grant is gnt=4'b0001.
REQ-031 req=4'b1111, fifo_full=0, macro on -> owner sequence 0,0,0,0,1,1,1,1,2,... with no bubbles; macro off -> 0,1,2,3,0,1.
REQ-032 Owner 1 after 2 beats; fifo_full=1 for 3 cycles -> gnt=0, wr_en=0, beat_cnt=2 held; then 2 more beats to owner 1, then rr_ptr=2.
REQ-033 Owner 0 drops req after 1 beat with req[3:1]=3'b111 -> one idle cycle, then gnt=4'b0010.
REQ-034 Only req[3] active, req_data[31:24]=8'hA5 -> wr_data=8'hA5, wr_en=1; after the burst, rr_ptr wraps to 0.
REQ-035 wr_rst pulsed in beat 2 of a burst to owner 2 with req=4'b1100 -> next grant after release is gnt=4'b0100 with beat_cnt restarting at 1.
